// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter for a single shared bus driven by up to 32 sources
// (register file R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C in the
// default 24-source configuration). A granted source owns the bus for a
// bounded tenure. The limit is lifted while lock is high. Every tenure is
// followed by one idle turnaround cycle before the next arbitration.
//
// Parameters
//   N_REQ    : number of requesters (2..32)
//   MAX_HOLD : maximum consecutive grant cycles per tenure (1..15)
//
// Ports
//   clock  : single rising-edge clock
//   clear  : synchronous active-high reset
//   req    : per-source bus requests, bit i = source i
//   lock   : exempts the current owner from the MAX_HOLD limit
//   grant  : registered one-hot bus-drive strobe (bits >= N_REQ always 0)
//   select : registered binary index of the granted source, 31 when idle
//   busy   : high whenever the arbiter is not in IDLE
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int N_REQ    = 24,
  parameter int MAX_HOLD = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N_REQ-1:0] req,
  input  logic             lock,
  output logic [31:0]      grant,
  output logic [4:0]       select,
  output logic             busy
);

  // Arbiter phases: waiting for requests, bus owned, turnaround cycle
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // select value reported while nobody drives the bus
  localparam logic [4:0] NO_SELECT = 5'd31;

  logic [1:0]  state_q,   state_d;
  logic [4:0]  rrPtr_q,   rrPtr_d;
  logic [3:0]  holdCnt_q, holdCnt_d;
  logic [31:0] grant_q,   grant_d;
  logic [4:0]  select_q,  select_d;

  logic [31:0] reqWide;
  logic        winnerFound;
  logic [4:0]  winnerIdx;
  logic [5:0]  candIdx;
  logic        holdSat;
  logic        ownerReq;
  logic        tenureEnd;
  logic [4:0]  nextPtr;

  // Zero-extend the request vector to 32 bits so that the owner index
  // (always a 5-bit value) can address it without width mismatches for
  // any legal N_REQ.
  always_comb begin
    reqWide = '0;
    reqWide[N_REQ-1:0] = req;
  end

  // Round-robin search: examine sources rrPtr, rrPtr+1, ... wrapping at
  // N_REQ-1 back to 0, and take the first one that requests. The candidate
  // is formed in 6 bits because rrPtr + offset can reach 62 before the
  // wrap correction brings it back into range.
  always_comb begin
    winnerFound = 1'b0;
    winnerIdx   = '0;
    candIdx     = '0;
    for (int off = 0; off < N_REQ; off++) begin
      candIdx = {1'b0, rrPtr_q} + 6'(off);
      if (candIdx >= 6'(N_REQ)) begin
        candIdx = candIdx - 6'(N_REQ);
      end
      if (!winnerFound && reqWide[candIdx[4:0]]) begin
        winnerFound = 1'b1;
        winnerIdx   = candIdx[4:0];
      end
    end
  end

  // Tenure bookkeeping for the current owner. While OWN is active the
  // owner index is exactly select_q, so no separate owner register is kept.
  // The tenure ends when the owner withdraws its request, or when the hold
  // counter has reached its ceiling and lock is not protecting the owner.
  // An owner whose request drops on the saturating cycle satisfies both
  // terms, but there is only one exit path so the pointer advances once.
  always_comb begin
    holdSat   = (holdCnt_q == 4'(MAX_HOLD - 1));
    ownerReq  = reqWide[select_q];
    tenureEnd = !ownerReq || (holdSat && !lock);
    if (select_q == 5'(N_REQ - 1)) begin
      nextPtr = '0;
    end else begin
      nextPtr = select_q + 5'd1;
    end
  end

  // Next-state logic. grant and select are computed here and registered,
  // so the bus strobe comes straight from flops and one edge after the
  // arbitration decision. Non-owner requests are only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    holdCnt_d = holdCnt_q;
    grant_d   = grant_q;
    select_d  = select_q;

    case (state_q)
      IDLE: begin
        grant_d  = '0;
        select_d = NO_SELECT;
        if (winnerFound) begin
          state_d   = OWN;
          grant_d   = 32'd1 << winnerIdx;
          select_d  = winnerIdx;
          holdCnt_d = '0;
        end
      end

      OWN: begin
        if (tenureEnd) begin
          state_d   = GAP;
          rrPtr_d   = nextPtr;
          holdCnt_d = '0;
          grant_d   = '0;
          select_d  = NO_SELECT;
        end else if (!holdSat) begin
          holdCnt_d = holdCnt_q + 4'd1;
        end
      end

      GAP: begin
        state_d  = IDLE;
        grant_d  = '0;
        select_d = NO_SELECT;
      end

      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        select_d = NO_SELECT;
      end
    endcase
  end

  // State registers. clear overrides everything, including an active
  // tenure: the grant drops at that edge and no turnaround cycle follows.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      holdCnt_q <= '0;
      grant_q   <= '0;
      select_q  <= NO_SELECT;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      holdCnt_q <= holdCnt_d;
      grant_q   <= grant_d;
      select_q  <= select_d;
    end
  end

  assign grant  = grant_q;
  assign select = select_q;
  assign busy   = (state_q != IDLE);

  // Structural guarantees of the registered outputs: never more than one
  // driver, and select always names the driver when there is one.
  assert property (@(posedge clock) disable iff (clear) $onehot0(grant_q));
  assert property (@(posedge clock) disable iff (clear)
                   (grant_q != '0) |-> (grant_q == (32'd1 << select_q)));

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Self-checking bench for bus_arbiter. A tenure-level reference model tracks
// who owns the bus, how many grant cycles the owner has had, whether a
// turnaround cycle is pending and where the next search starts. Directed
// sequences pin the model with literal expectations, then a long random
// phase exercises requests, lock and clear together.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int N_REQ    = 24;
  localparam int MAX_HOLD = 4;

  logic             clock;
  logic             clear;
  logic [N_REQ-1:0] req;
  logic             lock;
  logic [31:0]      grant;
  logic [4:0]       select;
  logic             busy;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  // Reference model: owner index (-1 = nobody), grant cycles served in the
  // current tenure, pending turnaround, next search start.
  int mOwner  = -1;
  int mTenure = 0;
  bit mGap    = 1'b0;
  int mPtr    = 0;

  // Fairness tally: tenures started per source during the all-request phase
  int          tally [N_REQ];
  bit          tallyEn   = 1'b0;
  logic [31:0] prevGrant = '0;

  bus_arbiter #(
    .N_REQ   (N_REQ),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clock (clock),
    .clear (clear),
    .req   (req),
    .lock  (lock),
    .grant (grant),
    .select(select),
    .busy  (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance the model at each rising edge using the inputs held across it.
  always @(posedge clock) begin
    bit found;
    if (clear) begin
      mOwner  = -1;
      mTenure = 0;
      mGap    = 1'b0;
      mPtr    = 0;
    end else if (mOwner >= 0) begin
      mTenure = mTenure + 1;
      if (!req[mOwner] || (mTenure >= MAX_HOLD && !lock)) begin
        mPtr   = (mOwner + 1) % N_REQ;
        mOwner = -1;
        mGap   = 1'b1;
      end
    end else if (mGap) begin
      mGap = 1'b0;
    end else begin
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && req[(mPtr + k) % N_REQ]) begin
          found   = 1'b1;
          mOwner  = (mPtr + k) % N_REQ;
          mTenure = 0;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model, on the falling
  // edge, away from the edge that updates the DUT registers.
  always @(negedge clock) begin
    logic [31:0] expGrant;
    logic [4:0]  expSelect;
    logic        expBusy;
    if (checkEn) begin
      expGrant  = (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0;
      expSelect = (mOwner >= 0) ? 5'(mOwner) : 5'd31;
      expBusy   = (mOwner >= 0) || mGap;
      testsRun++;
      if (grant !== expGrant || select !== expSelect || busy !== expBusy) begin
        testsFailed++;
        if (testsFailed <= 20) begin
          $display("[TB] FAIL model t=%0t: grant=%h select=%0d busy=%b, expected grant=%h select=%0d busy=%b",
                   $time, grant, select, busy, expGrant, expSelect, expBusy);
        end
      end
      if (tallyEn && grant != 32'd0 && prevGrant == 32'd0 && select < 5'(N_REQ)) begin
        tally[select]++;
      end
      prevGrant = grant;
    end
  end

  // Hold the given inputs for n rising edges; starts and ends on a falling edge.
  task automatic applyStimulus(input logic clr, input logic [N_REQ-1:0] r,
                               input logic lk, input int n);
    clear = clr;
    req   = r;
    lock  = lk;
    repeat (n) @(negedge clock);
  endtask

  // Literal expectation on the current outputs.
  task automatic checkOutput(input string name, input logic [31:0] expGrant,
                             input logic [4:0] expSelect, input logic expBusy);
    testsRun++;
    if (grant !== expGrant || select !== expSelect || busy !== expBusy) begin
      testsFailed++;
      $display("[TB] FAIL %s: grant=%h select=%0d busy=%b, expected grant=%h select=%0d busy=%b",
               name, grant, select, busy, expGrant, expSelect, expBusy);
    end
  endtask

  initial begin
    logic [31:0] rnd;
    int          starved;

    clear = 1'b1;
    req   = '0;
    lock  = 1'b0;
    @(negedge clock);

    // Reset state
    applyStimulus(1'b1, '0, 1'b0, 2);
    checkEn = 1'b1;
    checkOutput("reset", 32'h0, 5'd31, 1'b0);

    // Single request from source 8, then release
    applyStimulus(1'b0, 24'h000100, 1'b0, 1);
    checkOutput("single_grant", 32'h00000100, 5'd8, 1'b1);
    applyStimulus(1'b0, 24'h000000, 1'b0, 1);
    checkOutput("single_gap", 32'h0, 5'd31, 1'b1);
    applyStimulus(1'b0, 24'h000000, 1'b0, 1);
    checkOutput("single_idle", 32'h0, 5'd31, 1'b0);

    // Round robin between sources 0 and 2 with continuous requests
    applyStimulus(1'b1, '0, 1'b0, 1);
    applyStimulus(1'b0, 24'h000005, 1'b0, 4);
    checkOutput("rr_src0_last", 32'h1, 5'd0, 1'b1);
    applyStimulus(1'b0, 24'h000005, 1'b0, 1);
    checkOutput("rr_gap1", 32'h0, 5'd31, 1'b1);
    applyStimulus(1'b0, 24'h000005, 1'b0, 1);
    checkOutput("rr_idle1", 32'h0, 5'd31, 1'b0);
    applyStimulus(1'b0, 24'h000005, 1'b0, 1);
    checkOutput("rr_src2_first", 32'h4, 5'd2, 1'b1);
    applyStimulus(1'b0, 24'h000005, 1'b0, 3);
    checkOutput("rr_src2_last", 32'h4, 5'd2, 1'b1);
    applyStimulus(1'b0, 24'h000005, 1'b0, 1);
    checkOutput("rr_gap2", 32'h0, 5'd31, 1'b1);
    applyStimulus(1'b0, 24'h000005, 1'b0, 2);
    checkOutput("rr_src0_again", 32'h1, 5'd0, 1'b1);

    // Wrap-around: pointer at 23 after a source-22 tenure
    applyStimulus(1'b1, '0, 1'b0, 1);
    applyStimulus(1'b0, 24'h400000, 1'b0, 1);
    checkOutput("wrap_src22", 32'h00400000, 5'd22, 1'b1);
    applyStimulus(1'b0, 24'h000000, 1'b0, 1);
    applyStimulus(1'b0, 24'h800001, 1'b0, 2);
    checkOutput("wrap_src23", 32'h00800000, 5'd23, 1'b1);
    applyStimulus(1'b0, 24'h800001, 1'b0, 6);
    checkOutput("wrap_then_src0", 32'h1, 5'd0, 1'b1);

    // Lock keeps PC on the bus past the hold limit; releasing lock ends it
    applyStimulus(1'b1, '0, 1'b0, 1);
    applyStimulus(1'b0, 24'h100000, 1'b1, 10);
    checkOutput("lock_hold", 32'h00100000, 5'd20, 1'b1);
    applyStimulus(1'b0, 24'h100000, 1'b0, 1);
    checkOutput("lock_release_gap", 32'h0, 5'd31, 1'b1);

    // Reset in the middle of a source-21 tenure
    applyStimulus(1'b1, '0, 1'b0, 1);
    applyStimulus(1'b0, 24'h600000, 1'b0, 2);
    checkOutput("midreset_own", 32'h00200000, 5'd21, 1'b1);
    applyStimulus(1'b1, 24'h600000, 1'b0, 1);
    checkOutput("midreset_drop", 32'h0, 5'd31, 1'b0);
    applyStimulus(1'b0, 24'h600000, 1'b0, 1);
    checkOutput("midreset_regrant", 32'h00200000, 5'd21, 1'b1);

    // Every source requesting for 200 cycles
    applyStimulus(1'b1, '0, 1'b0, 1);
    for (int i = 0; i < N_REQ; i++) tally[i] = 0;
    tallyEn = 1'b1;
    applyStimulus(1'b0, 24'hFFFFFF, 1'b0, 7);
    checkOutput("all_src1", 32'h2, 5'd1, 1'b1);
    applyStimulus(1'b0, 24'hFFFFFF, 1'b0, 193);
    tallyEn = 1'b0;
    starved = 0;
    for (int i = 0; i < N_REQ; i++) if (tally[i] == 0) starved++;
    testsRun++;
    if (starved != 0) begin
      testsFailed++;
      $display("[TB] FAIL starvation: %0d sources never granted, expected 0", starved);
    end

    // Random phase: sparse, sticky requests with random lock and rare clear
    for (int c = 0; c < 3000; c++) begin
      clear = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 3) == 0) begin
        rnd = $urandom & $urandom & $urandom;
        req = rnd[N_REQ-1:0];
      end
      lock = ($urandom_range(0, 4) == 0);
      @(negedge clock);
    end

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
